// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NR     = 2;
  localparam int DEF_NW     = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_if.sv
// Bundle of the register-file datapath signals between issue/writeback and storage.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NR     = DEF_NR,
  parameter int NW     = DEF_NW
) ();

  logic [NR*ADDR_W-1:0] ra;
  logic [NR*DATA_W-1:0] rd;
  logic [NR-1:0]        rbusy;
  logic [NW-1:0]        we;
  logic [NW*ADDR_W-1:0] wa;
  logic [NW*DATA_W-1:0] wd;
  logic                 iss_v;
  logic [ADDR_W-1:0]    iss_a;
  logic [ADDR_W:0]      busy_cnt;

  // Pipeline side: issues reads, marks destinations, writes back results.
  modport master (
    output ra, we, wa, wd, iss_v, iss_a,
    input  rd, rbusy, busy_cnt
  );

  // Register-file side.
  modport slave (
    input  ra, we, wa, wd, iss_v, iss_a,
    output rd, rbusy, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection, plus a registered busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NW       = DEF_NW,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NW-1:0]            we,
  input  logic [NW*ADDR_W-1:0]     wa,
  input  logic                     iss_v,
  input  logic [ADDR_W-1:0]        iss_a,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_cnt_q, busy_cnt_d;

  // Next busy vector: writebacks clear, then issue sets so a new producer wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (we[j]) busy_d[wa[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_v) busy_d[iss_a] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Popcount of the next-state vector so the count lines up with busy after the edge.
  always_comb begin
    busy_cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[k]};
    end
  end

  // Busy state and count registers.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero, write-to-read bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NR       = DEF_NR,
  parameter int NW       = DEF_NW,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NR*ADDR_W-1:0] ra,
  output logic [NR*DATA_W-1:0] rd,
  output logic [NR-1:0]        rbusy,
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] wa,
  input  logic [NW*DATA_W-1:0] wd,
  input  logic                 iss_v,
  input  logic [ADDR_W-1:0]    iss_a,
  output logic [ADDR_W:0]      busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [ADDR_W-1:0] rsel;
  logic [DATA_W-1:0] rval;
  logic              rhit;

  // Write-port merge: later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    rf_d = rf_q;
    for (int j = 0; j < NW; j++) begin
      if (we[j] && !(ZERO_REG != 0 && wa[j*ADDR_W +: ADDR_W] == '0))
        rf_d[wa[j*ADDR_W +: ADDR_W]] = wd[j*DATA_W +: DATA_W];
    end
  end

  // Storage array, cleared by the asynchronous reset.
  // NOTE: the array is reset on purpose: reads must return 0 after a clear, so it maps to flops, not RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) rf_q[k] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports: zero register, then same-cycle bypass (highest write port), then storage.
  always_comb begin
    rd    = '0;
    rbusy = '0;
    rsel  = '0;
    rval  = '0;
    rhit  = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rsel = ra[i*ADDR_W +: ADDR_W];
      rval = rf_q[rsel];
      rhit = 1'b0;
      for (int j = 0; j < NW; j++) begin
        if (we[j] && wa[j*ADDR_W +: ADDR_W] == rsel) begin
          rval = wd[j*DATA_W +: DATA_W];
          rhit = 1'b1;
        end
      end
      if (ZERO_REG != 0 && rsel == '0) rval = '0;
      rd[i*DATA_W +: DATA_W] = rval;
      rbusy[i]               = busy[rsel] & ~rhit;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .we       (we),
    .wa       (wa),
    .iss_v    (iss_v),
    .iss_a    (iss_a),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; expectations are queued per cycle and checked by a monitor.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int NR = DEF_NR;
  localparam int NW = DEF_NW;

  typedef enum int {K_RD, K_BUSY, K_CNT} kind_e;
  typedef struct {
    string     name;
    kind_e     kind;
    int        port;
    reg_data_t val;
    int        cyc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NR(NR), .NW(NW), .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ra       (bus.ra),
    .rd       (bus.rd),
    .rbusy    (bus.rbusy),
    .we       (bus.we),
    .wa       (bus.wa),
    .wd       (bus.wd),
    .iss_v    (bus.iss_v),
    .iss_a    (bus.iss_a),
    .busy_cnt (bus.busy_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_val(input string name, input kind_e k, input int port, input reg_data_t v);
    exp_t e;
    e.name = name;
    e.kind = k;
    e.port = port;
    e.val  = v;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: at each falling edge, compare every expectation queued for this cycle.
  initial begin
    exp_t      e;
    reg_data_t act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc != cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
        end else begin
          case (e.kind)
            K_RD:    act = bus.rd[e.port*DW +: DW];
            K_BUSY:  act = {{(DW-1){1'b0}}, bus.rbusy[e.port]};
            default: act = {{(DW-AW-1){1'b0}}, bus.busy_cnt};
          endcase
          check(e.name, act, e.val);
        end
      end
    end
  end

  task automatic idle();
    bus.we    = '0;
    bus.iss_v = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_rd(input int i, input reg_addr_t a);
    bus.ra[i*AW +: AW] = a;
  endtask

  task automatic wr(input int j, input reg_addr_t a, input reg_data_t d);
    bus.we[j]          = 1'b1;
    bus.wa[j*AW +: AW] = a;
    bus.wd[j*DW +: DW] = d;
  endtask

  task automatic iss(input reg_addr_t a);
    bus.iss_v = 1'b1;
    bus.iss_a = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reg_addr_t a0, a1;
    bus.ra = '0; bus.we = '0; bus.wa = '0; bus.wd = '0;
    bus.iss_v = 1'b0; bus.iss_a = '0;

    // Held in reset
    step();
    set_rd(0, 5);
    expect_val("rst_rd", K_RD, 0, 32'h0);
    expect_val("rst_busy", K_BUSY, 0, 32'h0);
    expect_val("rst_cnt", K_CNT, 0, 32'd0);
    step();
    rstn = 1'b1;

    // Write r5 and mark it busy; bypass visible now
    step();
    wr(0, 5, 32'hDEAD_BEEF); iss(5); set_rd(0, 5);
    expect_val("r5_bypass", K_RD, 0, 32'hDEAD_BEEF);
    expect_val("r5_busy_same", K_BUSY, 0, 32'h0);
    step();
    expect_val("r5_stored", K_RD, 0, 32'hDEAD_BEEF);
    expect_val("r5_busy_next", K_BUSY, 0, 32'h1);
    expect_val("r5_cnt", K_CNT, 0, 32'd1);

    // Mid-cycle reset with a pending write and issue held across the edge
    step();
    rstn = 1'b0;
    wr(0, 4, 32'h1111); iss(6); set_rd(1, 6);
    expect_val("midrst_rd", K_RD, 0, 32'h0);
    expect_val("midrst_cnt", K_CNT, 0, 32'd0);
    expect_val("midrst_busy", K_BUSY, 1, 32'h0);
    step();
    rstn = 1'b1;
    set_rd(0, 4);
    expect_val("midrst_wr_dropped", K_RD, 0, 32'h0);
    expect_val("midrst_iss_dropped", K_BUSY, 1, 32'h0);
    expect_val("midrst_cnt_after", K_CNT, 0, 32'd0);

    // Zero register: write and issue to r0
    step();
    wr(0, 0, 32'h1234); iss(0); set_rd(0, 0); set_rd(1, 0);
    expect_val("zero_rd_same", K_RD, 0, 32'h0);
    expect_val("zero_busy_same", K_BUSY, 0, 32'h0);
    expect_val("zero_cnt_same", K_CNT, 0, 32'd0);
    step();
    expect_val("zero_rd_next", K_RD, 1, 32'h0);
    expect_val("zero_busy_next", K_BUSY, 0, 32'h0);
    expect_val("zero_cnt_next", K_CNT, 0, 32'd0);

    // Dual write to r7: port 1 wins
    step();
    wr(0, 7, 32'hAAAA); wr(1, 7, 32'hBBBB); set_rd(0, 7); set_rd(1, 7);
    expect_val("dual_bypass0", K_RD, 0, 32'hBBBB);
    expect_val("dual_bypass1", K_RD, 1, 32'hBBBB);
    step();
    expect_val("dual_stored", K_RD, 0, 32'hBBBB);

    // Scoreboard on r3
    step();
    iss(3); set_rd(0, 3);
    expect_val("r3_busy_same", K_BUSY, 0, 32'h0);
    expect_val("r3_cnt_same", K_CNT, 0, 32'd0);
    step();
    expect_val("r3_busy_next", K_BUSY, 0, 32'h1);
    expect_val("r3_cnt_next", K_CNT, 0, 32'd1);
    step();
    wr(1, 3, 32'h55);
    expect_val("r3_wb_unblock", K_BUSY, 0, 32'h0);
    expect_val("r3_wb_bypass", K_RD, 0, 32'h55);
    expect_val("r3_wb_cnt_same", K_CNT, 0, 32'd1);
    step();
    expect_val("r3_cnt_cleared", K_CNT, 0, 32'd0);
    expect_val("r3_busy_cleared", K_BUSY, 0, 32'h0);
    expect_val("r3_stored", K_RD, 0, 32'h55);

    // Set/clear collision on r9
    step();
    iss(9); set_rd(0, 9);
    step();
    expect_val("r9_busy", K_BUSY, 0, 32'h1);
    expect_val("r9_cnt", K_CNT, 0, 32'd1);
    step();
    wr(0, 9, 32'h9999); iss(9);
    expect_val("coll_rd_same", K_RD, 0, 32'h9999);
    expect_val("coll_busy_same", K_BUSY, 0, 32'h0);
    step();
    expect_val("coll_busy_next", K_BUSY, 0, 32'h1);
    expect_val("coll_rd_next", K_RD, 0, 32'h9999);
    expect_val("coll_cnt_next", K_CNT, 0, 32'd1);
    step();
    wr(0, 9, 32'h0);
    step();
    expect_val("r9_retired_cnt", K_CNT, 0, 32'd0);

    // Full occupancy: issue r1..r31 back to back
    for (int k = 1; k < 32; k++) begin
      step();
      iss(reg_addr_t'(k));
      expect_val($sformatf("fill_cnt_%0d", k), K_CNT, 0, reg_data_t'(k - 1));
    end
    step();
    set_rd(0, 1); set_rd(1, 31);
    expect_val("full_cnt", K_CNT, 0, 32'd31);
    expect_val("full_busy_r1", K_BUSY, 0, 32'h1);
    expect_val("full_busy_r31", K_BUSY, 1, 32'h1);

    // Drain: two writebacks per cycle for 16 cycles (last port-1 write hits r0)
    for (int c = 0; c < 16; c++) begin
      step();
      a0 = reg_addr_t'(2*c + 1);
      a1 = reg_addr_t'(2*c + 2);
      wr(0, a0, 32'h100 + 32'(a0)); wr(1, a1, 32'h100 + 32'(a1));
      set_rd(0, a0);
      expect_val($sformatf("drain_cnt_%0d", c), K_CNT, 0, reg_data_t'(31 - 2*c));
      expect_val($sformatf("drain_unblock_%0d", c), K_BUSY, 0, 32'h0);
      expect_val($sformatf("drain_bypass_%0d", c), K_RD, 0, 32'h100 + 32'(a0));
    end
    step();
    set_rd(0, 17); set_rd(1, 31);
    expect_val("empty_cnt", K_CNT, 0, 32'd0);
    expect_val("drain_r17", K_RD, 0, 32'h111);
    expect_val("drain_r31", K_RD, 1, 32'h11F);
    step();
    set_rd(0, 0); set_rd(1, 30);
    expect_val("drain_r0_dropped", K_RD, 0, 32'h0);
    expect_val("drain_r30", K_RD, 1, 32'h11E);

    step();
    step();
    check("queue_drained", reg_data_t'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined CPU datapath. It generalises the single-write, two-read synchronous register file with the following additions:
- configurable width, depth, read-port count and write-port count;
- asynchronous clear;
- hardwired zero register;
- same-cycle write-to-read bypass;
- per-register busy scoreboard that the issue stage uses to detect RAW hazards on in-flight destinations.

It sits between decode/issue (read ports, issue marking) and writeback (write ports).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NR, 2, number of read ports (1..4)
- NW, 2, number of write ports (1..2)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes, never becomes busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- ra  in  NR*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd  out  NR*DATA_W  read data, combinational
- rbusy  out  NR  busy flag of the register addressed by ra[i], combinational
- we  in  NW  write enables
- wa  in  NW*ADDR_W  write addresses
- wd  in  NW*DATA_W  write data
- iss_v  in  1  issue strobe: mark iss_a busy
- iss_a  in  ADDR_W  destination register being issued
- busy_cnt  out  ADDR_W+1  number of registers currently busy, registered

## Operation
- Storage: DEPTH x DATA_W flops; busy: DEPTH bits.
- Write, at the rising edge:
  - each port j with we[j]=1 writes wd[j] into rf[wa[j]];
  - if two ports target the same address, the highest-index port wins;
  - writes to register 0 are dropped when ZERO_REG=1.
- Read data, rd[i] (combinational), by priority:
  1. ZERO_REG=1 and ra[i]=0: 0.
  2. Any we[j] with wa[j]=ra[i] this cycle: wd of the highest such j (bypass).
  3. Otherwise rf[ra[i]].
- Scoreboard:
  - a write on port j clears busy[wa[j]];
  - iss_v sets busy[iss_a];
  - if issue and write hit the same address in one cycle, set wins (the new producer is in flight);
  - iss_a=0 is ignored when ZERO_REG=1.
- rbusy[i] = busy[ra[i]] & ~(any we[j] with wa[j]=ra[i]).
  - A same-cycle writeback unblocks, consistent with the bypass.
  - A same-cycle issue does not affect rbusy; the new busy bit is visible next cycle.
- busy_cnt is the registered popcount of the next-state busy vector, so it tracks busy with zero extra lag after the edge.

## Timing
- Reset (rstn low, asynchronous): all rf entries 0, all busy bits 0, busy_cnt 0.
  - rd outputs then read 0 unless a bypass is active.
  - rbusy is 0.
  - Deassertion is taken synchronously by the surrounding reset synchroniser.
- Reset asserted mid-cycle discards any write or issue in that cycle.
- Write latency: data is visible on rd through the bypass in the same cycle, and from storage from the next cycle on.
- Issue latency: busy is set and rbusy reflects it one cycle after iss_v.
- No handshake: iss_v and we are single-cycle strobes, and each is accepted every cycle.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W/NR/NW constants;
  - typedef reg_addr_t [ADDR_W-1:0];
  - typedef reg_data_t [DATA_W-1:0].
- Sub-module regfile_scoreboard holds:
  - busy vector, set/clear priority, popcount and busy_cnt register;
  - inputs: we, wa, iss_v, iss_a, rstn;
  - outputs: busy vector and busy_cnt.
- The top level holds storage, the write-port priority mux, and the read/bypass muxes.

## Test plan
- Reset: write rf[5]=32'hDEAD_BEEF, then pulse rstn low mid-cycle.
  - Required: rd for ra=5 returns 0 immediately.
  - Required: busy_cnt=0.
- Zero register: we[0]=1, wa=0, wd=32'h1234 and iss_v=1, iss_a=0.
  - Required: rd(ra=0)=0 in the same and the next cycle.
  - Required: rbusy=0 and busy_cnt unchanged.
- Bypass and dual write: same cycle, port0 writes r7=32'hAAAA and port1 writes r7=32'hBBBB.
  - Required: rd(ra=7)=32'hBBBB in the same cycle.
  - Required: rf[7]=32'hBBBB after the edge.
- Scoreboard: iss_v, r3.
  - Required: next cycle rbusy(ra=3)=1 and busy_cnt=1.
  - Then: a write of r3=32'h55 gives rbusy=0 and rd=32'h55 in the same cycle; busy_cnt=0 next cycle.
- Set/clear collision: r9 is busy; in one cycle, write r9 and iss_v r9.
  - Required: next cycle rbusy(ra=9)=1, rd=written value, busy_cnt unchanged.
- Full occupancy: issue r1..r31 on consecutive cycles.
  - Required: busy_cnt=31.
  - Then: clear all 31 via both write ports, two per cycle, for 16 cycles; required busy_cnt=0.
